// File: rtl/im_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit words and writes them.
// Optional trailing XOR checksum byte is enabled by defining IM_LOADER_CKSUM_EN.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded,
  output logic        cpu_hold
);

`ifdef IM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {StIdle, StHdr, StData, StWr, StDone, StErr, StCksum} state_e;
  localparam state_e StFinish = StCksum;
`else
  typedef enum logic [2:0] {StIdle, StHdr, StData, StWr, StDone, StErr} state_e;
  localparam state_e StFinish = StDone;
`endif

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [15:0] count_q, count_d;
  logic [15:0] words_q, words_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] hdr_n;
  logic        hs;
`ifdef IM_LOADER_CKSUM_EN
  logic [7:0]  cksum_q, cksum_d;
`endif

  assign hs    = in_valid && in_ready;
  assign hdr_n = {count_q[15:8], in_data};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    count_d    = count_q;
    words_d    = words_q;
    addr_d     = addr_q;
`ifdef IM_LOADER_CKSUM_EN
    cksum_d    = cksum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StHdr;
          byte_cnt_d = 2'd0;
          shift_d    = 32'h0;
          count_d    = 16'h0;
          words_d    = 16'h0;
          addr_d     = BASE_ADDR;
`ifdef IM_LOADER_CKSUM_EN
          cksum_d    = 8'h00;
`endif
        end
      end
      StHdr: begin
        if (hs) begin
          if (byte_cnt_q == 2'd0) begin
            count_d    = {in_data, 8'h00};
            byte_cnt_d = 2'd1;
          end else begin
            count_d    = hdr_n;
            byte_cnt_d = 2'd0;
            if (hdr_n == 16'h0) begin
              state_d = StFinish;
            end else if ({16'h0, hdr_n} > MAX_WORDS) begin
              state_d = StErr;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (hs) begin
          shift_d    = {shift_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IM_LOADER_CKSUM_EN
          cksum_d    = cksum_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            state_d = StWr;
          end
        end
      end
      StWr: begin
        words_d = words_q + 16'd1;
        addr_d  = addr_q + 32'd4;
        state_d = (words_q + 16'd1 == count_q) ? StFinish : StData;
      end
`ifdef IM_LOADER_CKSUM_EN
      StCksum: begin
        if (hs) begin
          state_d = (in_data == cksum_q) ? StDone : StErr;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'h0;
      count_q    <= 16'h0;
      words_q    <= 16'h0;
      addr_q     <= BASE_ADDR;
`ifdef IM_LOADER_CKSUM_EN
      cksum_q    <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
`ifdef IM_LOADER_CKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  // Checksum wait is still part of the load, so the CPU stays held there.
`ifdef IM_LOADER_CKSUM_EN
  assign in_ready = (state_q == StHdr) || (state_q == StData) || (state_q == StCksum);
  assign busy     = (state_q == StHdr) || (state_q == StData) || (state_q == StWr) ||
                    (state_q == StCksum);
`else
  assign in_ready = (state_q == StHdr) || (state_q == StData);
  assign busy     = (state_q == StHdr) || (state_q == StData) || (state_q == StWr);
`endif

  assign im_we        = (state_q == StWr);
  assign im_addr      = addr_q;
  assign im_wdata     = shift_q;
  assign done         = (state_q == StDone);
  assign err          = (state_q == StErr);
  assign words_loaded = words_q;
  assign cpu_hold     = busy;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader; expected writes go through a scoreboard queue.
// Covers IM_LOADER_CKSUM_EN cases when that macro is defined.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int exp_we = 0;
  logic prev_we = 1'b0;
  logic rdy_mon = 1'b0;
  logic [63:0] exp_q[$];

  im_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (256)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .cpu_hold     (cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
    exp_we++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) break;
    end
    chk("handshake_timeout", 64'(n > 50), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_prog2(input int gap);
    logic [7:0] bytes [10] = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                               8'h00, 8'h22, 8'h18, 8'h20};
    for (int i = 0; i < 10; i++) send_byte(bytes[i], gap);
  endtask

  // Scoreboard and write-strobe monitor.
  always @(negedge clk) begin
    if (im_we) begin
      we_cnt++;
      chk("we_single_cycle", 64'(prev_we), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {im_addr, im_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("write_addr_data", {im_addr, im_wdata}, exp_q.pop_front());
      end
    end
    if (rdy_mon && busy) chk("ready_only_drops_in_wr", 64'(in_ready), 64'(!im_we));
    prev_we = im_we;
  end

  initial begin
    // Reset values
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_addr", 64'(im_addr), 64'h0);
    chk("rst_done_err", {62'd0, done, err}, 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-word load, in_valid held high
    pulse_start();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_ready", 64'(in_ready), 64'd1);
    expect_wr(32'h0, 32'h2001_0005);
    expect_wr(32'h4, 32'h0022_1820);
    send_prog2(0);
`ifdef IM_LOADER_CKSUM_EN
    send_byte(8'h20 ^ 8'h01 ^ 8'h05 ^ 8'h22 ^ 8'h18 ^ 8'h20, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("p1_done", 64'(done), 64'd1);
    chk("p1_words", 64'(words_loaded), 64'd2);
    chk("p1_hold", 64'(cpu_hold), 64'd0);
    chk("p1_we_count", 64'(we_cnt), 64'(exp_we));

    // Same program with 3-cycle gaps between bytes
    pulse_start();
    chk("p2_done_cleared", {62'd0, done, err}, 64'd0);
    chk("p2_words_cleared", 64'(words_loaded), 64'd0);
    rdy_mon = 1'b1;
    expect_wr(32'h0, 32'h2001_0005);
    expect_wr(32'h4, 32'h0022_1820);
    send_prog2(3);
`ifdef IM_LOADER_CKSUM_EN
    send_byte(8'h20 ^ 8'h01 ^ 8'h05 ^ 8'h22 ^ 8'h18 ^ 8'h20, 3);
`endif
    rdy_mon = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("p2_done", 64'(done), 64'd1);
    chk("p2_words", 64'(words_loaded), 64'd2);
    chk("p2_we_count", 64'(we_cnt), 64'(exp_we));

    // Zero-length header
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IM_LOADER_CKSUM_EN
    chk("n0_wait_cksum", 64'(busy), 64'd1);
    send_byte(8'h00, 0);
`endif
    chk("n0_done", 64'(done), 64'd1);
    chk("n0_busy", 64'(busy), 64'd0);
    chk("n0_words", 64'(words_loaded), 64'd0);

    // Oversized header, then restart out of ERR
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("big_err", 64'(err), 64'd1);
    chk("big_done", 64'(done), 64'd0);
    chk("big_ready", 64'(in_ready), 64'd0);
    chk("big_busy", 64'(busy), 64'd0);
    pulse_start();
    chk("restart_err", 64'(err), 64'd0);
    chk("restart_hdr", {62'd0, busy, in_ready}, 64'd3);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IM_LOADER_CKSUM_EN
    send_byte(8'h00, 0);
`endif
    chk("restart_done", 64'(done), 64'd1);
    chk("no_write_count", 64'(we_cnt), 64'(exp_we));

    // Reset in the middle of a load; start while busy is ignored
    pulse_start();
    expect_wr(32'h0, 32'hAABB_CCDD);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    send_byte(8'h11, 0);
    pulse_start();
    chk("busy_start_ignored_words", 64'(words_loaded), 64'd1);
    chk("busy_start_ignored_addr", 64'(im_addr), 64'h4);
    send_byte(8'h22, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy_hold", {62'd0, busy, cpu_hold}, 64'd0);
    chk("arst_ready_we", {62'd0, in_ready, im_we}, 64'd0);
    chk("arst_addr", 64'(im_addr), 64'h0);
    chk("arst_wdata", 64'(im_wdata), 64'h0);
    chk("arst_words", 64'(words_loaded), 64'd0);
    chk("arst_done_err", {62'd0, done, err}, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_no_more_writes", 64'(we_cnt), 64'(exp_we));
    chk("arst_idle", 64'(busy), 64'd0);

`ifdef IM_LOADER_CKSUM_EN
    // Checksum good, then bad
    pulse_start();
    expect_wr(32'h0, 32'hAABB_CCDD);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    send_byte(8'h00, 0);
    chk("ck_good_done", {62'd0, done, err}, 64'd2);
    pulse_start();
    expect_wr(32'h0, 32'hAABB_CCDD);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    send_byte(8'h01, 0);
    chk("ck_bad_err", {62'd0, done, err}, 64'd1);
    chk("ck_bad_words", 64'(words_loaded), 64'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_we_count", 64'(we_cnt), 64'(exp_we));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer-side companion to the instruction memory. The pipelined CPU only reads instructions from it; this block fills it.
- Accepts a byte stream over a valid/ready handshake, packs the bytes into big-endian 32-bit instruction words and issues single-cycle word writes to the instruction memory.
- Holds the CPU (cpu_hold) while a program load is in progress.
- Sits beside the CPU top level, between the host or bench byte source and the instruction memory write port.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
- MAX_WORDS, 256, largest word count accepted in the header; a larger count is an error.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a load
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a byte; transfer occurs when in_valid && in_ready
- im_we  output  1  instruction memory write strobe, one cycle per word
- im_addr  output  32  byte address of the word being written
- im_wdata  output  32  word being written
- busy  output  1  load in progress
- done  output  1  last load completed successfully (level)
- err  output  1  last load aborted (level)
- words_loaded  output  16  number of words written in the current or last load
- cpu_hold  output  1  equals busy; CPU fetch must be stalled while high

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. Every output is 0 except im_addr, which is BASE_ADDR. Internal byte counter, word shift register and count register are cleared.
- Reset mid-load: the load aborts immediately. Words already written stay in memory.
- States: IDLE, HDR, DATA, WR, DONE, ERR.
- start is honoured only in IDLE, DONE or ERR; it is ignored while busy.
- Accepting start: go to HDR; clear done, err, words_loaded and the byte counter; set im_addr = BASE_ADDR.
- HDR: in_ready=1. Accepts 2 bytes as the big-endian word count N (first byte is bits 15:8).
  - After the 2nd byte: N==0 → DONE. N>MAX_WORDS → ERR. Otherwise → DATA.
- DATA: in_ready=1. Each accepted byte shifts into the word register MSB-first (first byte is bits 31:24).
  - On the 4th accepted byte → WR.
- WR: lasts exactly one cycle.
  - im_we=1, im_wdata = assembled word, im_addr = BASE_ADDR + 4*words_loaded, in_ready=0.
  - Latency: im_we is high in the cycle after the 4th byte handshake.
- Leaving WR:
  - words_loaded increments and im_addr advances by 4. im_addr wraps modulo 2^32.
  - If words_loaded == N → DONE (or the checksum step, see Optional Feature); else → DATA.
- busy=1 and cpu_hold=1 in HDR, DATA and WR; both are 0 otherwise.
- DONE: done=1 and in_ready=0 until the next accepted start.
- ERR: err=1 and in_ready=0 until the next accepted start.
- Bytes presented while in_ready=0 are not consumed; the source must hold them.
- in_valid may drop between bytes; a gap of any length is legal.
- im_we is never high outside WR, and never high for more than one consecutive cycle.

Optional Feature:
- Macro: IM_LOADER_CKSUM_EN.
- Defined: after the N-th word's WR, enter state CKSUM with in_ready=1 and accept one byte. If it equals the XOR of all payload bytes (header bytes excluded) → DONE; otherwise → ERR. Words already written are not rolled back. When N==0, the CKSUM state expects byte 8'h00.
- Undefined: no CKSUM state exists and the last WR goes straight to DONE.

Test Plan:
- Reset, then start; stream 00 02 / 20 01 00 05 / 00 22 18 20 with in_valid held high:
  - exactly two im_we pulses: (0x0,0x20010005) and (0x4,0x00221820);
  - done=1, words_loaded=2, cpu_hold=0 afterwards.
- Same stream, but in_valid low for 3 cycles between every byte: identical writes; in_ready never drops except in WR cycles.
- Header 00 00: no im_we, done=1, busy=0 two handshakes after start. With IM_LOADER_CKSUM_EN defined, byte 00 is additionally required.
- Header 01 01 (N=257, exceeding MAX_WORDS=256): err=1, no im_we, in_ready=0; a following start re-enters HDR with err=0.
- Assert rst_n low after the 6th payload byte of a 2-word load:
  - outputs return to reset values asynchronously;
  - word 0 remains written and no second im_we appears;
  - a start pulse while busy (before the reset) is shown to be ignored.
- With IM_LOADER_CKSUM_EN, 1 word AA BB CC DD:
  - checksum byte 00 → done=1;
  - checksum byte 01 → err=1, with the word still written at 0x0.
